// File: rtl/imagine_pkg.sv
// Shared definitions for the complex datapath: operand widths, ALU opcodes
// and the power-sequencer state encoding.
package imagine_pkg;

  localparam int NUMBER_SIZE = 8;
  localparam int OP_SIZE     = 4;

  localparam logic [OP_SIZE-1:0] MUL_OP  = 4'b0010;
  localparam logic [OP_SIZE-1:0] MOVE_OP = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } pow_state_e;

endpackage

// File: rtl/complex_pow_seq.sv
// Square-and-multiply sequencer computing z^n through the shared complex ALU,
// issuing one MUL per granted cycle and idling the ALU lines otherwise.
module complex_pow_seq
  import imagine_pkg::*;
#(
  parameter int EXP_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUMBER_SIZE-1:0] z_re,
  input  logic [NUMBER_SIZE-1:0] z_im,
  input  logic [EXP_W-1:0]       exp,
  output logic                   busy,
  output logic                   done,
  output logic [NUMBER_SIZE-1:0] res_re,
  output logic [NUMBER_SIZE-1:0] res_im,
  output logic                   alu_req,
  input  logic                   alu_gnt,
  output logic [NUMBER_SIZE-1:0] alu_a1,
  output logic [NUMBER_SIZE-1:0] alu_a2,
  output logic [NUMBER_SIZE-1:0] alu_b1,
  output logic [NUMBER_SIZE-1:0] alu_b2,
  output logic [OP_SIZE-1:0]     alu_op,
  input  logic [NUMBER_SIZE-1:0] alu_out1,
  input  logic [NUMBER_SIZE-1:0] alu_out2
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0]       IDX_TOP = IDX_W'(EXP_W - 1);
  localparam logic [NUMBER_SIZE-1:0] ONE     = NUMBER_SIZE'(1);

  pow_state_e             state_q, state_d;
  logic [NUMBER_SIZE-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [NUMBER_SIZE-1:0] zr_re_q, zr_re_d, zr_im_q, zr_im_d;
  logic [NUMBER_SIZE-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
  logic [EXP_W-1:0]       er_q, er_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_re_q <= '0;
      acc_im_q <= '0;
      zr_re_q  <= '0;
      zr_im_q  <= '0;
      er_q     <= '0;
      idx_q    <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      zr_re_q  <= zr_re_d;
      zr_im_q  <= zr_im_d;
      er_q     <= er_d;
      idx_q    <= idx_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    zr_re_d  = zr_re_q;
    zr_im_d  = zr_im_q;
    er_d     = er_q;
    idx_d    = idx_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    done     = 1'b0;
    alu_req  = 1'b0;
    alu_op   = MOVE_OP;
    alu_a1   = '0;
    alu_a2   = '0;
    alu_b1   = '0;
    alu_b2   = '0;

    // The result register is loaded on the edge into DONE so it is already
    // valid while done is high.
    case (state_q)
      IDLE: begin
        if (start) begin
          zr_re_d  = z_re;
          zr_im_d  = z_im;
          er_d     = exp;
          acc_re_d = ONE;
          acc_im_d = '0;
          idx_d    = IDX_TOP;
          state_d  = SQ;
        end
      end
      SQ: begin
        alu_req = 1'b1;
        alu_op  = MUL_OP;
        alu_a1  = acc_re_q;
        alu_a2  = acc_im_q;
        alu_b1  = acc_re_q;
        alu_b2  = acc_im_q;
        if (alu_gnt) begin
          acc_re_d = alu_out1;
          acc_im_d = alu_out2;
          if (er_q[idx_q]) begin
            state_d = MUL;
          end else if (idx_q == '0) begin
            state_d  = DONE;
            res_re_d = alu_out1;
            res_im_d = alu_out2;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      MUL: begin
        alu_req = 1'b1;
        alu_op  = MUL_OP;
        alu_a1  = acc_re_q;
        alu_a2  = acc_im_q;
        alu_b1  = zr_re_q;
        alu_b2  = zr_im_q;
        if (alu_gnt) begin
          acc_re_d = alu_out1;
          acc_im_d = alu_out2;
          if (idx_q == '0) begin
            state_d  = DONE;
            res_re_d = alu_out1;
            res_im_d = alu_out2;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQ;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign res_re = res_re_q;
  assign res_im = res_im_q;

endmodule

// File: tb/tb_complex_pow_seq.sv
// Self-checking bench for complex_pow_seq with a behavioural ALU and a
// repeated-multiplication reference model for z^n mod 256.
module tb_complex_pow_seq;
  import imagine_pkg::*;

  localparam int EXP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       z_re = '0, z_im = '0;
  logic [EXP_W-1:0] exp = '0;
  logic             busy, done, alu_req;
  logic             alu_gnt = 1'b1;
  logic [7:0]       res_re, res_im;
  logic [7:0]       alu_a1, alu_a2, alu_b1, alu_b2, alu_out1, alu_out2;
  logic [3:0]       alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] re;
    logic [7:0] im;
    int         done_cycle;
    int         denied;
    int         viol;
    logic       done_after;
    logic       busy_after;
    logic [7:0] re_after;
  } run_t;

  complex_pow_seq #(.EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .z_re(z_re), .z_im(z_im), .exp(exp),
    .busy(busy), .done(done), .res_re(res_re), .res_im(res_im),
    .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_b1(alu_b1), .alu_b2(alu_b2),
    .alu_op(alu_op), .alu_out1(alu_out1), .alu_out2(alu_out2)
  );

  always #5 clk = ~clk;

  // Environment ALU: the MUL result computed in 8-bit context wraps mod 256.
  assign alu_out1 = (alu_op == MUL_OP) ? alu_a1 * alu_b1 - alu_a2 * alu_b2 : alu_a1;
  assign alu_out2 = (alu_op == MUL_OP) ? alu_a1 * alu_b2 + alu_a2 * alu_b1 : alu_a2;

  function automatic void pow_model(input logic [7:0] re, input logic [7:0] im, input int e,
                                    output logic [7:0] rr, output logic [7:0] ri);
    int ar, ai, t, zr, zi;
    ar = 1; ai = 0; zr = int'(re); zi = int'(im);
    for (int i = 0; i < e; i++) begin
      t  = (ar * zr - ai * zi) & 255;
      ai = (ar * zi + ai * zr) & 255;
      ar = t;
    end
    rr = 8'(ar);
    ri = 8'(ai);
  endfunction

  // gmode: 0 grant always, 1 denied on odd cycles, 2 random grant.
  task automatic run_op(input logic [7:0] zr, input logic [7:0] zi, input logic [3:0] e,
                        input int gmode, input int inject_cycle, output run_t r);
    int cyc;
    logic prev_den;
    logic [31:0] prev_ops;
    r.re = '0; r.im = '0; r.done_cycle = -1; r.denied = 0; r.viol = 0;
    r.done_after = 1'b1; r.busy_after = 1'b1; r.re_after = '0;
    @(posedge clk); #1;
    start = 1'b1; z_re = zr; z_im = zi; exp = e; alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; z_re = 8'($urandom); z_im = 8'($urandom); exp = 4'($urandom);
    cyc = 1; prev_den = 1'b0; prev_ops = '0;
    while (r.done_cycle < 0 && cyc < 200) begin
      if (done === 1'b1) begin
        r.done_cycle = cyc; r.re = res_re; r.im = res_im;
        if (alu_req !== 1'b0 || alu_op !== MOVE_OP || busy !== 1'b1) r.viol++;
      end else begin
        case (gmode)
          0:       alu_gnt = 1'b1;
          1:       alu_gnt = ~cyc[0];
          default: alu_gnt = 1'($urandom_range(0, 1));
        endcase
        start = (cyc == inject_cycle);
        if (busy !== 1'b1 || alu_req !== 1'b1 || alu_op !== MUL_OP) r.viol++;
        if (prev_den && {alu_a1, alu_a2, alu_b1, alu_b2} !== prev_ops) r.viol++;
        prev_den = ~alu_gnt;
        if (prev_den) r.denied++;
        prev_ops = {alu_a1, alu_a2, alu_b1, alu_b2};
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0; alu_gnt = 1'b1;
    if (r.done_cycle >= 0) begin
      @(posedge clk); #1;
      r.done_after = done; r.busy_after = busy; r.re_after = res_re;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got busy=%b done=%b req=%b expected 000", busy, done, alu_req);
    end
    n_checks++;
    if (res_re !== 8'h00 || res_im !== 8'h00) begin
      n_fail++; $display("[TB] FAIL reset_res: got %h,%h expected 00,00", res_re, res_im);
    end
    n_checks++;
    if (alu_op !== MOVE_OP || {alu_a1, alu_a2, alu_b1, alu_b2} !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_alu: got op=%b ops=%h expected 0111/0", alu_op, {alu_a1, alu_a2, alu_b1, alu_b2});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] vre [4] = '{8'd0, 8'd1, 8'd16, 8'd5};
    logic [7:0] vim [4] = '{8'd1, 8'd1, 8'd0, 8'hFD};
    logic [3:0] vex [4] = '{4'd2, 4'd3, 4'd2, 4'd0};
    logic [7:0] ere [4] = '{8'hFF, 8'hFE, 8'h00, 8'h01};
    logic [7:0] eim [4] = '{8'h00, 8'h02, 8'h00, 8'h00};
    int         ecy [4] = '{6, 7, 6, 5};
    run_t r;
    for (int i = 0; i < 4; i++) begin
      run_op(vre[i], vim[i], vex[i], 0, 0, r);
      n_checks++;
      if (r.re !== ere[i] || r.im !== eim[i]) begin
        n_fail++; $display("[TB] FAIL basic_res[%0d]: got %h,%h expected %h,%h", i, r.re, r.im, ere[i], eim[i]);
      end
      n_checks++;
      if (r.done_cycle !== ecy[i]) begin
        n_fail++; $display("[TB] FAIL basic_latency[%0d]: got %0d expected %0d", i, r.done_cycle, ecy[i]);
      end
      n_checks++;
      if (r.viol !== 0) begin
        n_fail++; $display("[TB] FAIL basic_protocol[%0d]: got %0d violations expected 0", i, r.viol);
      end
      n_checks++;
      if (r.done_after !== 1'b0 || r.busy_after !== 1'b0 || r.re_after !== ere[i]) begin
        n_fail++; $display("[TB] FAIL basic_after[%0d]: got done=%b busy=%b res=%h expected 0 0 %h",
                           i, r.done_after, r.busy_after, r.re_after, ere[i]);
      end
    end
  endtask

  task automatic test_denied_grant();
    run_t r;
    run_op(8'd1, 8'd1, 4'd3, 1, 0, r);
    n_checks++;
    if (r.re !== 8'hFE || r.im !== 8'h02) begin
      n_fail++; $display("[TB] FAIL denied_res: got %h,%h expected fe,02", r.re, r.im);
    end
    n_checks++;
    if (r.done_cycle !== 13 || r.done_cycle !== 7 + r.denied) begin
      n_fail++; $display("[TB] FAIL denied_latency: got %0d (denied %0d) expected 13", r.done_cycle, r.denied);
    end
    n_checks++;
    if (r.viol !== 0) begin
      n_fail++; $display("[TB] FAIL denied_protocol: got %0d violations expected 0", r.viol);
    end
  endtask

  task automatic test_start_ignored();
    run_t r;
    run_op(8'd1, 8'd1, 4'd3, 0, 2, r);
    n_checks++;
    if (r.re !== 8'hFE || r.im !== 8'h02 || r.done_cycle !== 7) begin
      n_fail++; $display("[TB] FAIL start_busy: got %h,%h cycle %0d expected fe,02 cycle 7", r.re, r.im, r.done_cycle);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    run_t r;
    @(posedge clk); #1;
    start = 1'b1; z_re = 8'd1; z_im = 8'd1; exp = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (alu_req !== 1'b1 || alu_b1 !== 8'd1 || alu_b2 !== 8'd1) begin
      n_fail++; $display("[TB] FAIL mid_in_mul: got req=%b b=%h,%h expected 1 01,01", alu_req, alu_b1, alu_b2);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0 || res_re !== 8'h00 || res_im !== 8'h00) begin
      n_fail++; $display("[TB] FAIL mid_reset: got busy=%b done=%b req=%b res=%h,%h expected 0 0 0 00,00",
                         busy, done, alu_req, res_re, res_im);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("[TB] FAIL mid_no_done: got %0d pulses expected 0", pulses);
    end
    run_op(8'd0, 8'd1, 4'd2, 0, 0, r);
    n_checks++;
    if (r.re !== 8'hFF || r.im !== 8'h00 || r.done_cycle !== 6) begin
      n_fail++; $display("[TB] FAIL mid_restart: got %h,%h cycle %0d expected ff,00 cycle 6", r.re, r.im, r.done_cycle);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic seen;
    @(posedge clk); #1;
    start = 1'b1; z_re = 8'd2; z_im = 8'd0; exp = 4'd3;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || res_re !== 8'd8 || res_im !== 8'd0) begin
      n_fail++; $display("[TB] FAIL b2b_first: got seen=%b res=%h,%h expected 1 08,00", seen, res_re, res_im);
    end
    z_re = 8'd0; z_im = 8'd1; exp = 4'd2;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_idle_gap: got busy=%b expected 0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_accept: got busy=%b expected 1", busy);
    end
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (res_re !== 8'hFF || res_im !== 8'h00 || cyc !== 6) begin
      n_fail++; $display("[TB] FAIL b2b_second: got %h,%h cycle %0d expected ff,00 cycle 6", res_re, res_im, cyc);
    end
  endtask

  task automatic test_random();
    logic [7:0] zr, zi, mr, mi;
    logic [3:0] e;
    run_t r;
    for (int i = 0; i < 1000; i++) begin
      zr = 8'($urandom); zi = 8'($urandom); e = 4'($urandom);
      run_op(zr, zi, e, 2, 0, r);
      pow_model(zr, zi, int'(e), mr, mi);
      n_checks++;
      if (r.re !== mr || r.im !== mi) begin
        n_fail++; $display("[TB] FAIL rand_res: z=%h,%h n=%0d got %h,%h expected %h,%h", zr, zi, e, r.re, r.im, mr, mi);
      end
      n_checks++;
      if (r.done_cycle !== EXP_W + $countones(e) + 1 + r.denied) begin
        n_fail++; $display("[TB] FAIL rand_latency: n=%0d got %0d expected %0d", e, r.done_cycle,
                           EXP_W + $countones(e) + 1 + r.denied);
      end
      n_checks++;
      if (r.viol !== 0) begin
        n_fail++; $display("[TB] FAIL rand_protocol: got %0d violations expected 0", r.viol);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_denied_grant();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
